// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - shared constants and types for the MPU matrix loader
package mpu_pkg;

  localparam int MPU_ROWS        = 5;
  localparam int MPU_COLS        = 5;
  localparam int MPU_ELEM_W      = 8;
  localparam int MPU_FRAME_WORDS = MPU_ROWS * MPU_COLS + 1;
  localparam int MPU_FLAT_W      = MPU_ROWS * MPU_COLS * MPU_ELEM_W;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } loader_state_e;

endpackage

// File: rtl/mpu_rc_counter.sv
// rtl/mpu_rc_counter.sv - factor phase plus row/column slot tracker for frame assembly
module mpu_rc_counter #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int RW   = 3,
  parameter int CW   = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic          o_factor_phase,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_tc
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic          r_factor_phase;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_tc;

  assign w_tc = !r_factor_phase && (r_row == ROW_LAST) && (r_col == COL_LAST);

  // Advancing past the last element wraps straight back to the factor slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_factor_phase <= 1'b1;
      r_row          <= '0;
      r_col          <= '0;
    end else if (i_clr) begin
      r_factor_phase <= 1'b1;
      r_row          <= '0;
      r_col          <= '0;
    end else if (i_adv) begin
      if (r_factor_phase) begin
        r_factor_phase <= 1'b0;
      end else if (w_tc) begin
        r_factor_phase <= 1'b1;
        r_row          <= '0;
        r_col          <= '0;
      end else if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_factor_phase = r_factor_phase;
  assign o_row          = r_row;
  assign o_col          = r_col;
  assign o_tc           = w_tc;

endmodule

// File: rtl/mpu_matrix_loader.sv
// rtl/mpu_matrix_loader.sv - assembles factor plus matrix from a word stream and holds it for the multiplier
module mpu_matrix_loader
  import mpu_pkg::*;
#(
  parameter int ROWS   = MPU_ROWS,
  parameter int COLS   = MPU_COLS,
  parameter int ELEM_W = MPU_ELEM_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ELEM_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROWS*COLS*ELEM_W-1:0] out_matrix,
  output logic [ELEM_W-1:0]           out_factor,
  output logic                        err_len
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [0:0] ST_LOAD = 1'(LOAD);
  localparam logic [0:0] ST_HOLD = 1'(HOLD);

  logic [0:0]                  r_state;
  logic                        r_in_ready;
  logic                        r_err_len;
  logic [ROWS*COLS*ELEM_W-1:0] r_matrix;
  logic [ELEM_W-1:0]           r_factor;

  logic          w_accept;
  logic          w_early;
  logic          w_done;
  logic          w_factor_phase;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_tc;
  logic [0:0]    w_next_state;

  assign w_accept = in_valid && r_in_ready && (r_state == ST_LOAD);
  assign w_early  = w_accept && in_last && !w_tc;
  assign w_done   = w_accept && w_tc;

  mpu_rc_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_rc_counter (
    .clock          (clock),
    .reset          (reset),
    .i_clr          (w_early),
    .i_adv          (w_accept && !w_early),
    .o_factor_phase (w_factor_phase),
    .o_row          (w_row),
    .o_col          (w_col),
    .o_tc           (w_tc)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD: if (w_done) w_next_state = ST_HOLD;
      ST_HOLD: if (out_ready) w_next_state = ST_LOAD;
      default: w_next_state = ST_LOAD;
    endcase
  end

  // in_ready is registered so it stays low through reset and rises on the first clock after.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_LOAD;
      r_in_ready <= 1'b0;
      r_err_len  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == ST_LOAD);
      r_err_len  <= w_early || (w_done && !in_last);
    end
  end

  // Slot decode compares row/col against constant indices, so no divide or modulo is needed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_matrix <= '0;
      r_factor <= '0;
    end else if (w_accept) begin
      if (w_factor_phase) begin
        r_factor <= in_data;
      end else begin
        for (int i = 0; i < ROWS; i++) begin
          for (int j = 0; j < COLS; j++) begin
            if ((w_row == RW'(i)) && (w_col == CW'(j))) begin
              r_matrix[ELEM_W*(i*COLS+j) +: ELEM_W] <= in_data;
            end
          end
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state == ST_HOLD);
  assign out_matrix = r_matrix;
  assign out_factor = r_factor;
  assign err_len    = r_err_len;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// tb/tb_mpu_matrix_loader.sv - directed self-checking bench for mpu_matrix_loader
module tb_mpu_matrix_loader;
  import mpu_pkg::*;

  logic                  clock;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [MPU_ELEM_W-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [MPU_FLAT_W-1:0] out_matrix;
  logic [MPU_ELEM_W-1:0] out_factor;
  logic                  err_len;

  int n_checks;
  int n_fail;
  int err_cnt;
  bit ov_seen;

  mpu_matrix_loader dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_matrix (out_matrix),
    .out_factor (out_factor),
    .err_len    (err_len)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (err_len) err_cnt = err_cnt + 1;
    if (out_valid) ov_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MPU_FLAT_W-1:0] exp_mat(input logic [7:0] base);
    logic [MPU_FLAT_W-1:0] m;
    m = '0;
    for (int k = 0; k < MPU_ROWS * MPU_COLS; k++) m[8*k +: 8] = base + 8'(k);
    return m;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put_word(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Word 0 is the factor, word k is element base+k-1; in_last on index last_at.
  task automatic send_words(input logic [7:0] factor, input logic [7:0] base,
                            input int n_words, input int last_at, input int gap_max);
    for (int k = 0; k < n_words; k++) begin
      if (gap_max > 0) begin
        int gaps;
        gaps = $urandom_range(gap_max, 0);
        for (int g = 0; g < gaps; g++) tick();
      end
      put_word((k == 0) ? factor : base + 8'(k - 1), k == last_at);
    end
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [MPU_FLAT_W-1:0] held;
    n_checks  = 0;
    n_fail    = 0;
    err_cnt   = 0;
    ov_seen   = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_matrix", out_matrix, 0);
    check("rst_factor", out_factor, 0);
    check("rst_err", err_len, 0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // 1: nominal frame
    err_cnt = 0;
    send_words(8'h03, 8'h01, 25, -1, 0);
    check("t1_not_yet_valid", out_valid, 0);
    put_word(8'h19, 1'b1);
    check("t1_out_valid", out_valid, 1);
    check("t1_in_ready", in_ready, 0);
    check("t1_factor", out_factor, 8'h03);
    check("t1_e00", out_matrix[0 +: 8], 8'h01);
    check("t1_e23", out_matrix[8*(2*5+3) +: 8], 8'h0E);
    check("t1_e44", out_matrix[8*(4*5+4) +: 8], 8'h19);
    check("t1_matrix", out_matrix, exp_mat(8'h01));
    tick();
    check("t1_no_err", err_cnt, 0);

    // 2: backpressure hold with junk traffic
    held = out_matrix;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 8'hAA;
      tick();
      check("t2_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("t2_valid_held", out_valid, 1);
    check("t2_matrix_held", out_matrix, held);
    check("t2_factor_held", out_factor, 8'h03);
    release_frame();
    check("t2_valid_fall", out_valid, 0);
    check("t2_ready_rise", in_ready, 1);

    // 3: early last on index 10, then a full frame
    err_cnt = 0;
    ov_seen = 1'b0;
    send_words(8'h55, 8'h40, 11, 10, 0);
    check("t3_err_pulse", err_len, 1);
    tick();
    check("t3_err_one_cycle", err_len, 0);
    check("t3_no_valid", ov_seen, 0);
    send_words(8'h07, 8'h80, 26, 25, 0);
    check("t3_valid", out_valid, 1);
    check("t3_factor", out_factor, 8'h07);
    check("t3_matrix", out_matrix, exp_mat(8'h80));
    check("t3_err_count", err_cnt, 1);
    release_frame();

    // 4: missing last
    err_cnt = 0;
    send_words(8'h11, 8'h20, 26, -1, 0);
    check("t4_valid", out_valid, 1);
    check("t4_err_pulse", err_len, 1);
    check("t4_factor", out_factor, 8'h11);
    check("t4_matrix", out_matrix, exp_mat(8'h20));
    tick();
    check("t4_err_one_cycle", err_len, 0);
    release_frame();

    // 5: gapped input
    err_cnt = 0;
    send_words(8'hC3, 8'h60, 25, -1, 2);
    tick();
    tick();
    tick();
    check("t5_not_yet_valid", out_valid, 0);
    put_word(8'h78, 1'b1);
    check("t5_valid", out_valid, 1);
    check("t5_factor", out_factor, 8'hC3);
    check("t5_matrix", out_matrix, exp_mat(8'h60));
    tick();
    check("t5_no_err", err_cnt, 0);
    release_frame();

    // 6: asynchronous reset mid-frame
    send_words(8'h99, 8'h01, 12, -1, 0);
    #2 reset = 1'b1;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_matrix_zero", out_matrix, 0);
    check("t6_factor_zero", out_factor, 0);
    check("t6_in_ready", in_ready, 0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_ready_back", in_ready, 1);
    send_words(8'h42, 8'hA0, 26, 25, 0);
    check("t6_valid_after", out_valid, 1);
    check("t6_factor_after", out_factor, 8'h42);
    check("t6_matrix_after", out_matrix, exp_mat(8'hA0));
    release_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
